// File: rtl/ps2_rx_frame_if.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// | Module   : ps2_rx_frame_if                                              |
// | Purpose  : PS/2 receive-side bundle: line inputs, enable and results.   |
// | Revision : 1.0  initial release                                         |
// ---------------------------------------------------------------------------
interface ps2_rx_frame_if;
  logic       ps2_c;
  logic       ps2_d;
  logic       rx_en;
  logic [7:0] dout;
  logic       rx_done;
  logic       rx_err;
  logic       rx_idle;

  // The side that owns the PS/2 lines and consumes received bytes.
  modport master (
    output ps2_c, ps2_d, rx_en,
    input  dout, rx_done, rx_err, rx_idle
  );

  // The receiver itself.
  modport slave (
    input  ps2_c, ps2_d, rx_en,
    output dout, rx_done, rx_err, rx_idle
  );
endinterface
`default_nettype wire

// File: rtl/ps2_rx_frame.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// | Module   : ps2_rx_frame                                                 |
// | Purpose  : PS/2 device-to-host receiver. Deserialises 11-bit frames     |
// |            (start, 8 data LSB first, odd parity, stop) with clock       |
// |            glitch filtering and an inter-edge timeout.                  |
// | Revision : 1.0  initial release                                         |
// ---------------------------------------------------------------------------
module ps2_rx_frame #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic            clk,
  input  logic            rst,
  ps2_rx_frame_if.slave   bus
);

  localparam int FW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  // Leaving RECV on the edge where the counter would reach TIMEOUT_CYCLES-1
  // puts the error pulse exactly TIMEOUT_CYCLES cycles after the last edge.
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 2);

  typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1, CHECK = 2'd2} state_t;

  logic          c_s1, c_s2, d_s1, d_s2;
  logic          filt, filt_d;
  logic [FW-1:0] fcnt;
  logic          fall_tick;

  state_t        state, state_n;
  logic [9:0]    shreg, shreg_n;
  logic [3:0]    bitcnt, bitcnt_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [7:0]    dout_q, dout_n;
  logic          done_q, done_n;
  logic          err_q, err_n;

  // Two-flop synchronisers for both asynchronous PS/2 lines; idle level is 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_s1 <= 1'b1; c_s2 <= 1'b1;
      d_s1 <= 1'b1; d_s2 <= 1'b1;
    end else begin
      c_s1 <= bus.ps2_c; c_s2 <= c_s1;
      d_s1 <= bus.ps2_d; d_s2 <= d_s1;
    end
  end

  // Clock filter: level changes only after FILTER_LEN consecutive opposite samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt   <= 1'b1;
      filt_d <= 1'b1;
      fcnt   <= '0;
    end else begin
      filt_d <= filt;
      if (c_s2 != filt) begin
        if (fcnt == FILT_LAST) begin
          filt <= c_s2;
          fcnt <= '0;
        end else begin
          fcnt <= fcnt + 1'b1;
        end
      end else begin
        fcnt <= '0;
      end
    end
  end

  assign fall_tick = filt_d & ~filt;

  // Frame state and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      shreg  <= '0;
      bitcnt <= '0;
      tcnt   <= '0;
      dout_q <= 8'h00;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_n;
      shreg  <= shreg_n;
      bitcnt <= bitcnt_n;
      tcnt   <= tcnt_n;
      dout_q <= dout_n;
      done_q <= done_n;
      err_q  <= err_n;
    end
  end

  // Next-state logic: start detect, bit shifting, timeout and frame check.
  always_comb begin
    state_n  = state;
    shreg_n  = shreg;
    bitcnt_n = bitcnt;
    tcnt_n   = tcnt;
    dout_n   = dout_q;
    done_n   = 1'b0;
    err_n    = 1'b0;
    case (state)
      IDLE: begin
        if (fall_tick && bus.rx_en && !d_s2) begin
          state_n  = RECV;
          bitcnt_n = '0;
          tcnt_n   = '0;
        end
      end
      RECV: begin
        if (fall_tick) begin
          // Bits enter at the MSB so after ten shifts data sits in [7:0].
          shreg_n = {d_s2, shreg[9:1]};
          tcnt_n  = '0;
          if (bitcnt == 4'd9) begin
            state_n = CHECK;
          end else begin
            bitcnt_n = bitcnt + 4'd1;
          end
        end else if (tcnt == TMO_LAST) begin
          state_n = IDLE;
          err_n   = 1'b1;
        end else begin
          tcnt_n = tcnt + 1'b1;
        end
      end
      CHECK: begin
        state_n = IDLE;
        if (shreg[9] && (^shreg[8:0])) begin
          dout_n = shreg[7:0];
          done_n = 1'b1;
        end else begin
          err_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.dout    = dout_q;
  assign bus.rx_done = done_q;
  assign bus.rx_err  = err_q;
  assign bus.rx_idle = (state == IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx_frame.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// | Module   : tb_ps2_rx_frame                                              |
// | Purpose  : Directed self-checking bench for ps2_rx_frame.               |
// | Revision : 1.0  initial release                                         |
// ---------------------------------------------------------------------------
module tb_ps2_rx_frame;

  localparam int FL = 8;
  localparam int TO = 2000;
  // Latencies counted in clk edges from the edge after ps2_c is driven low:
  // 2 sync + FL filter gives fall_tick, then CHECK, then the registered pulse.
  localparam int DONE_LAT = FL + 4;
  localparam int TMO_LAT  = FL + 2 + TO;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  ps2_rx_frame_if bus ();

  ps2_rx_frame #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0, busy_cnt = 0;
  int done_at, err_at;
  int d0, e0, b0;

  // Pulse and busy bookkeeping sampled away from the active edge.
  always @(negedge clk) begin
    if (bus.rx_done) done_cnt++;
    if (bus.rx_err) err_cnt++;
    if (bus.rx_done && bus.rx_err) both_cnt++;
    if (!bus.rx_idle) busy_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    d0 = done_cnt; e0 = err_cnt; b0 = busy_cnt;
  endtask

  // Drives nfall bits of a frame; records pulse latency after the last fall.
  task automatic send_frame(input logic [7:0] data, input bit bad_par = 1'b0,
                            input bit bad_stop = 1'b0, input int nfall = 11,
                            input int half = 60, input int watch = 60,
                            input int glitch_bit = -1, input bit drop_en = 1'b0);
    logic [10:0] bits;
    bits = {~bad_stop, (~^data) ^ bad_par, data, 1'b0};
    done_at = 0;
    err_at  = 0;
    for (int i = 0; i < nfall; i++) begin
      bus.ps2_d = bits[i];
      if (i == glitch_bit) begin
        tick(half / 3);
        bus.ps2_c = 1'b0;
        tick(3);
        bus.ps2_c = 1'b1;
        tick(half - half / 3 - 3);
      end else begin
        tick(half);
      end
      bus.ps2_c = 1'b0;
      if (i == nfall - 1) begin
        for (int k = 1; k <= watch; k++) begin
          tick(1);
          if (bus.rx_done && done_at == 0) done_at = k;
          if (bus.rx_err && err_at == 0) err_at = k;
          if (k == half) bus.ps2_c = 1'b1;
        end
        bus.ps2_c = 1'b1;
      end else begin
        tick(half);
        bus.ps2_c = 1'b1;
        if (drop_en && i == 0) bus.rx_en = 1'b0;
      end
    end
    bus.ps2_d = 1'b1;
    tick(40);
  endtask

  initial begin
    bus.ps2_c = 1'b1;
    bus.ps2_d = 1'b1;
    bus.rx_en = 1'b1;
    tick(5);
    chk("rst_dout", bus.dout, 32'h00);
    chk("rst_done", bus.rx_done, 0);
    chk("rst_err", bus.rx_err, 0);
    chk("rst_idle", bus.rx_idle, 1);
    rst = 1'b0;
    tick(20);

    // 0xFA at 20 us period (500 clk half period).
    snap();
    send_frame(8'hFA, 0, 0, 11, 500, 500);
    chk("fa_latency", done_at, DONE_LAT);
    chk("fa_dout", bus.dout, 32'hFA);
    chk("fa_done_cnt", done_cnt - d0, 1);
    chk("fa_no_err", err_cnt - e0, 0);
    chk("fa_idle", bus.rx_idle, 1);

    // Bad parity keeps previous byte; then 0x01.
    snap();
    send_frame(8'hFA, 1, 0);
    chk("par_err_lat", err_at, DONE_LAT);
    chk("par_err_cnt", err_cnt - e0, 1);
    chk("par_no_done", done_cnt - d0, 0);
    chk("par_dout_hold", bus.dout, 32'hFA);
    send_frame(8'h01);
    chk("x01_dout", bus.dout, 32'h01);

    // Clocking stops after 5 bits.
    snap();
    send_frame(8'h3C, 0, 0, 5, 60, 2100);
    chk("tmo_latency", err_at, TMO_LAT);
    chk("tmo_err_cnt", err_cnt - e0, 1);
    chk("tmo_no_done", done_cnt - d0, 0);
    chk("tmo_idle", bus.rx_idle, 1);
    send_frame(8'hAA);
    chk("aa_dout", bus.dout, 32'hAA);

    // Short low glitch on ps2_c inside a high phase.
    snap();
    send_frame(8'h55, 0, 0, 11, 60, 60, 4);
    chk("glitch_dout", bus.dout, 32'h55);
    chk("glitch_done", done_cnt - d0, 1);
    chk("glitch_no_err", err_cnt - e0, 0);
    snap();
    send_frame(8'h66, 0, 1);
    chk("stop_err", err_cnt - e0, 1);
    chk("stop_no_done", done_cnt - d0, 0);
    chk("stop_dout_hold", bus.dout, 32'h55);

    // Receiver disabled at start bit.
    bus.rx_en = 1'b0;
    snap();
    send_frame(8'h12);
    chk("dis_no_done", done_cnt - d0, 0);
    chk("dis_no_err", err_cnt - e0, 0);
    chk("dis_never_busy", busy_cnt - b0, 0);
    chk("dis_dout_hold", bus.dout, 32'h55);
    bus.rx_en = 1'b1;
    tick(10);
    send_frame(8'h34, 0, 0, 11, 60, 60, -1, 1);
    chk("drop_en_dout", bus.dout, 32'h34);
    bus.rx_en = 1'b1;

    // Reset mid-frame.
    snap();
    send_frame(8'hF4, 0, 0, 6);
    chk("mid_busy", bus.rx_idle, 0);
    rst = 1'b1;
    tick(3);
    chk("mid_rst_dout", bus.dout, 32'h00);
    chk("mid_rst_idle", bus.rx_idle, 1);
    rst = 1'b0;
    tick(20);
    chk("mid_rst_no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);
    send_frame(8'hF4);
    chk("f4_dout", bus.dout, 32'hF4);
    chk("f4_latency", done_at, DONE_LAT);

    chk("never_both", both_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ps2_rx_frame.md
Name: ps2_rx_frame

Overview:
PS/2 device-to-host receiver. It deserialises 11-bit frames (start, 8 data LSB-first, odd parity, stop) clocked by the keyboard or mouse on ps2_c. It is the receive-side counterpart of the host transmitter in the PS/2 controller and shares the same ps2_c/ps2_d lines. When the transmitter is idle, the controller top level routes the lines here and gates reception with rx_en.

Parameters:
FILTER_LEN, 8, consecutive equal samples of synchronised ps2_c needed to change the filtered clock level (minimum 2).
TIMEOUT_CYCLES, 100000, maximum clk cycles allowed between filtered ps2_c falling edges inside a frame; 2 ms at 50 MHz.

Ports:
clk  in  1  system clock, 50 MHz.
rst  in  1  asynchronous, active-high reset.
ps2_c  in  1  PS/2 clock line, asynchronous to clk.
ps2_d  in  1  PS/2 data line, asynchronous to clk.
rx_en  in  1  1 = a new frame may start; it is sampled only when a start bit is detected.
dout  out  8  last correctly received byte.
rx_done  out  1  one-cycle pulse: dout updated with a valid byte.
rx_err  out  1  one-cycle pulse: frame rejected (parity, stop or timeout).
rx_idle  out  1  1 while in IDLE.

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE, dout=8'h00, rx_done=0, rx_err=0, rx_idle=1.
  - Shift register, bit counter and timeout counter cleared.
  - Synchroniser and filter reset to 1.
  - Reset mid-frame discards the partial frame with no pulse.
- Input conditioning:
  - ps2_c and ps2_d each pass through a 2-FF synchroniser.
  - Filtered clock goes to 1 after FILTER_LEN consecutive 1 samples, goes to 0 after FILTER_LEN consecutive 0 samples, and otherwise holds.
  - fall_tick is a one-cycle pulse when the filtered clock goes 1->0.
  - Data is sampled from synchronised ps2_d in the fall_tick cycle.
- FSM states: IDLE, RECV, CHECK.
  - IDLE: on fall_tick with rx_en=1 and data=0 -> RECV, bitcnt=0, timeout counter=0. A fall_tick with data=1, or with rx_en=0, is ignored and the FSM stays in IDLE.
  - RECV: each fall_tick shifts data into a 10-bit register from the MSB side (data[0..7], parity, stop) and increments bitcnt. On the 10th fall_tick (bitcnt=9) -> CHECK.
  - RECV timeout: the counter increments every cycle and clears on fall_tick. When it reaches TIMEOUT_CYCLES-1 -> IDLE with rx_err=1 for one cycle.
  - rx_en falling mid-frame has no effect; the frame completes.
  - CHECK (one cycle) -> IDLE always.
    - Valid frame (stop=1 and XOR(data,parity)=1): dout<=data, rx_done=1.
    - Otherwise: rx_err=1 and dout holds its previous value.
- Timing:
  - rx_done/rx_err are registered and high in the cycle after CHECK, which is 2 clk cycles after the stop-bit fall_tick.
  - rx_done and rx_err are never high together.
  - rx_idle=0 from the cycle after the start-bit fall_tick until the return to IDLE.
- Minimum legal ps2_c half-period is 2*FILTER_LEN+4 clk cycles; shorter pulses are treated as glitches.

Test Plan:
- Device frame 0xFA (bits 0,0,1,0,1,1,1,1,1,1,1) at 20 us ps2_c period, rx_en=1 -> rx_done pulse 2 clks after 11th falling edge, dout=8'hFA, rx_err never 1, rx_idle back to 1.
- Frame 0xFA with parity bit forced 0 -> rx_err single pulse, rx_done=0, dout keeps 8'hFA from the prior frame; then 0x01 (parity 0) -> dout=8'h01.
- TIMEOUT_CYCLES=2000, clocking stops after 5 bits -> rx_err pulse exactly 2000 cycles after last fall_tick, rx_idle=1; next 0xAA frame -> dout=8'hAA.
- 3-cycle low glitch on ps2_c during a high phase of a 0x55 frame; stop bit driven 0 in a separate frame -> first frame gives dout=8'h55 (glitch ignored), second gives rx_err.
- rx_en=0 at start of a 0x12 frame -> no pulses, rx_idle stays 1. rx_en dropped after start bit of a 0x34 frame -> dout=8'h34.
- rst pulsed after 6 bits of a frame -> dout=0, rx_idle=1, no pulse; the following complete 0xF4 frame is received correctly.
